// File: rtl/simple_isa_pkg.sv
// Shared encodings for the 16-bit SIMPLE ISA: opcode/field constants, the ID/EX
// control bundle and the interlock FSM state codes.
package simple_isa_pkg;

  // Primary opcode, instr[15:14]
  localparam logic [1:0] Op1Ld  = 2'b00;
  localparam logic [1:0] Op1St  = 2'b01;
  localparam logic [1:0] Op1Imm = 2'b10;
  localparam logic [1:0] Op1Alu = 2'b11;

  // Field positions
  localparam int unsigned Op1Lo = 14;
  localparam int unsigned RsLo  = 11;
  localparam int unsigned RdLo  = 8;
  localparam int unsigned Op3Lo = 4;

  // rs-field sub-opcodes under Op1Imm
  localparam logic [2:0] RsLi  = 3'b000;
  localparam logic [2:0] RsB   = 3'b100;
  localparam logic [2:0] RsBcc = 3'b111;

  // Secondary opcode under Op1Alu, instr[7:4]
  localparam logic [3:0] Op3AluLast = 4'b0110;
  localparam logic [3:0] Op3Cmp     = 4'b0101;
  localparam logic [3:0] Op3ShFirst = 4'b1000;
  localparam logic [3:0] Op3ShLast  = 4'b1011;
  localparam logic [3:0] Op3In      = 4'b1100;
  localparam logic [3:0] Op3Out     = 4'b1101;
  localparam logic [3:0] Op3Hlt     = 4'b1111;

  // Control bundle handed to ID/EX
  typedef struct packed {
    logic sw1;          // ALU-B = immediate
    logic sw2;          // memory read
    logic sw3;          // memory write
    logic sw4;          // write-back from memory
    logic sw5;          // branch
    logic sw6;          // OUT port enable
    logic sw7;          // shift op
    logic write_order;  // register-file write enable
  } ctrl_t;

  // Interlock FSM states
  typedef logic [1:0] state_t;
  localparam state_t StRun   = 2'd0;
  localparam state_t StStall = 2'd1;
  localparam state_t StFlush = 2'd2;
  localparam state_t StHalt  = 2'd3;

endpackage

// File: rtl/id_decode.sv
// Combinational instruction decoder: IF/ID instruction -> control bundle plus
// flags telling which register fields the instruction reads.
module id_decode
  import simple_isa_pkg::*;
(
  input  logic [15:0] instr_i,
  output ctrl_t       ctrl_o,
  output logic        use_rs_o,
  output logic        use_rd_o,
  output logic        is_hlt_o
);

  logic [1:0] op1;
  logic [2:0] rs;
  logic [3:0] op3;

  assign op1 = instr_i[Op1Lo +: 2];
  assign rs  = instr_i[RsLo +: 3];
  assign op3 = instr_i[Op3Lo +: 4];

  // Opcode decode; anything unlisted falls through as an all-zero NOP
  always_comb begin
    ctrl_o   = '0;
    use_rs_o = 1'b0;
    use_rd_o = 1'b0;
    is_hlt_o = 1'b0;
    unique case (op1)
      Op1Ld: begin
        ctrl_o.sw1         = 1'b1;
        ctrl_o.sw2         = 1'b1;
        ctrl_o.sw4         = 1'b1;
        ctrl_o.write_order = 1'b1;
        use_rd_o           = 1'b1;  // base register rb sits in the rd field
      end
      Op1St: begin
        ctrl_o.sw1 = 1'b1;
        ctrl_o.sw3 = 1'b1;
        use_rs_o   = 1'b1;
        use_rd_o   = 1'b1;
      end
      Op1Imm: begin
        if (rs == RsLi) begin
          ctrl_o.sw1         = 1'b1;
          ctrl_o.write_order = 1'b1;
        end else if (rs == RsB || rs == RsBcc) begin
          ctrl_o.sw1 = 1'b1;
          ctrl_o.sw5 = 1'b1;
        end
      end
      Op1Alu: begin
        if (op3 <= Op3AluLast) begin
          ctrl_o.write_order = (op3 != Op3Cmp);
          use_rs_o           = 1'b1;
          use_rd_o           = 1'b1;
        end else if (op3 >= Op3ShFirst && op3 <= Op3ShLast) begin
          ctrl_o.sw7         = 1'b1;
          ctrl_o.write_order = 1'b1;
          use_rs_o           = 1'b1;
          use_rd_o           = 1'b1;
        end else if (op3 == Op3In) begin
          ctrl_o.write_order = 1'b1;
        end else if (op3 == Op3Out) begin
          ctrl_o.sw6 = 1'b1;
          use_rs_o   = 1'b1;
          use_rd_o   = 1'b1;
        end else if (op3 == Op3Hlt) begin
          is_hlt_o = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID-stage control: decodes IF/ID into ID/EX controls and runs the pipeline
// interlock (load-use / RAW stall, taken-branch flush, halt).
// Build option: define ID_FORWARD_EN when EX->ID and MEM->ID bypasses exist;
// then only load-use stalls. Without it any RAW against EX or MEM stalls.
module id_hazard_ctrl
  import simple_isa_pkg::*;
#(
  parameter int unsigned FLUSH_DEPTH = 2,
  parameter int unsigned REG_AW      = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic [15:0]       instr,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_load,
  input  logic              ex_wr,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_wr,
  input  logic              br_taken,
  output logic              sw1,
  output logic              sw2,
  output logic              sw3,
  output logic              sw4,
  output logic              sw5,
  output logic              sw6,
  output logic              sw7,
  output logic              writeOrder,
  output logic              stall,
  output logic              halted
);

  localparam logic [1:0] FlushInit = 2'(FLUSH_DEPTH - 1);

  ctrl_t             dec_ctrl;
  ctrl_t             out_ctrl;
  logic              use_rs;
  logic              use_rd;
  logic              is_hlt;
  logic [REG_AW-1:0] src_rs;
  logic [REG_AW-1:0] src_rd;
  logic              ex_hit;
  logic              mem_hit;
  logic              hazard;
  logic              bubble;
  logic              stall_c;
  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;

  id_decode u_decode (
    .instr_i  (instr),
    .ctrl_o   (dec_ctrl),
    .use_rs_o (use_rs),
    .use_rd_o (use_rd),
    .is_hlt_o (is_hlt)
  );

  assign src_rs = instr[RsLo +: REG_AW];
  assign src_rd = instr[RdLo +: REG_AW];

  // Source-register match against the EX and MEM destinations
  always_comb begin
    ex_hit  = (use_rs && src_rs == ex_rd)  || (use_rd && src_rd == ex_rd);
    mem_hit = (use_rs && src_rs == mem_rd) || (use_rd && src_rd == mem_rd);
`ifdef ID_FORWARD_EN
    // Bypasses cover everything except data still coming out of memory
    hazard = instr_valid && ex_hit && ex_wr && ex_load;
`else
    hazard = instr_valid && ((ex_hit && ex_wr) || (mem_hit && mem_wr));
`endif
  end

`ifdef ID_FORWARD_EN
  logic unused_mem;
  assign unused_mem = ^{mem_rd, mem_wr};
`endif

  // Interlock next-state; bubble defaults on and is cleared only when issuing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bubble  = 1'b1;
    stall_c = 1'b0;
    case (state_q)
      StRun, StStall: begin
        if (br_taken) begin
          state_d = (FLUSH_DEPTH > 1) ? StFlush : StRun;
          cnt_d   = FlushInit;
        end else if (hazard) begin
          stall_c = 1'b1;
          state_d = StStall;
        end else begin
          state_d = StRun;
          if (instr_valid && is_hlt) begin
            state_d = StHalt;  // HLT itself leaves ID as a NOP
          end else begin
            bubble = !instr_valid;
          end
        end
      end
      StFlush: begin
        if (br_taken) begin
          cnt_d = FlushInit;
        end else if (cnt_q <= 2'd1) begin
          state_d = StRun;
          cnt_d   = 2'd0;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      StHalt: begin
        stall_c = 1'b1;
      end
      default: begin
        state_d = StRun;
        cnt_d   = 2'd0;
      end
    endcase
  end

  // State registers, synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StRun;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output gating: bubble or reset forces all controls low
  always_comb begin
    out_ctrl   = (bubble || reset) ? '0 : dec_ctrl;
    sw1        = out_ctrl.sw1;
    sw2        = out_ctrl.sw2;
    sw3        = out_ctrl.sw3;
    sw4        = out_ctrl.sw4;
    sw5        = out_ctrl.sw5;
    sw6        = out_ctrl.sw6;
    sw7        = out_ctrl.sw7;
    writeOrder = out_ctrl.write_order;
    stall      = stall_c && !reset;
    halted     = (state_q == StHalt) && !reset;
  end

endmodule
